fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage directly upstream of the RAM instruction port.
//   Holds the program counter, drives the RAM address, and latches the word returned on fetch_out.
//   Presents each instruction to decode with a valid/ready handshake.
//   Supports branch redirect. Never writes memory.
// PARAMETERS
//   DATA_SIZE     32  instruction/data word width (matches RAM)
//   ADDRESS_SIZE  16  word address width (matches RAM)
//   RESET_PC      0   PC value loaded on reset
// PORTS
//   clk             in   1             single clock, all state updates on rising edge
//   reset           in   1             synchronous, active-high
//   enable          in   1             1 = fetching permitted
//   mem_req         out  1             fetch requests RAM port (arbiter input)
//   mem_grant       in   1             RAM port granted to fetch this cycle
//   mem_address     out  ADDRESS_SIZE  registered address to RAM
//   mem_read_write  out  1             constant 1 (read)
//   mem_fetch_data  in   DATA_SIZE     RAM fetch_out
//   instr           out  DATA_SIZE     latched instruction
//   instr_pc        out  ADDRESS_SIZE  address instr was fetched from
//   instr_valid     out  1             instr/instr_pc valid for decode
//   instr_ready     in   1             decode accepts instr this cycle
//   branch_valid    in   1             redirect request (1 cycle pulse)
//   branch_target   in   ADDRESS_SIZE  redirect address
//   pc              out  ADDRESS_SIZE  next address to fetch
// BEHAVIOUR
//   Reset values (same cycle as reset edge):
//     state=IDLE, pc=RESET_PC, mem_address=RESET_PC, instr=0, instr_pc=0,
//     instr_valid=0, mem_req=0. Reset overrides all other inputs.
//   FSM states:
//   IDLE: mem_req=0.
//     If enable=1, load mem_address<=pc and go to ADDR.
//   ADDR: mem_req=1; RAM settles on mem_address.
//     If mem_grant=1, go to CAPTURE; otherwise stay in ADDR.
//   CAPTURE: mem_req=1.
//     If mem_grant=1: instr<=mem_fetch_data, instr_pc<=mem_address, instr_valid<=1,
//       pc<=pc+1, then go to HOLD.
//     If mem_grant=0: no capture and pc unchanged; go back to ADDR (retry).
//   HOLD: mem_req=0; instr, instr_pc and instr_valid stay stable.
//     If instr_ready=1: instr_valid<=0 and mem_address<=pc; go to ADDR if enable=1, else IDLE.
//   Latency and throughput:
//     Latency is 2 cycles from entering ADDR with grant held to instr_valid=1.
//     Max throughput is 1 instruction per 3 cycles.
//   PC arithmetic: pc+1 is modulo 2^ADDRESS_SIZE, so all-ones wraps to 0. Word addressed.
//   enable=0 mid-fetch: the current fetch completes and is delivered; the FSM parks in IDLE after the handshake.
//   branch_valid=1 (priority over everything except reset), in any state:
//     pc<=branch_target, mem_address<=branch_target, instr_valid<=0.
//     Any in-flight CAPTURE result is discarded.
//     A held instruction is squashed, even if instr_ready=1 in the same cycle.
//     Next state is ADDR if enable=1, else IDLE.
//   mem_read_write is tied to 1; fetch never asserts a write.
//   mem_fetch_data is sampled only in CAPTURE with mem_grant=1; it is don't-care otherwise.
// TESTING
//   1 Reset; mem[0]=32'hA5A50001; enable=1, grant=1, ready=1
//     -> instr_valid=1 two cycles after ADDR entry, instr=32'hA5A50001, instr_pc=0, pc=1.
//   2 Same as 1, but ready=0 for 5 cycles
//     -> instr/instr_pc stable, instr_valid=1, mem_req=0, pc=1.
//     Ready=1 then gives next fetch address 1.
//   3 grant=0 in the CAPTURE cycle
//     -> no instr_valid, FSM returns to ADDR, pc unchanged.
//     Once grant returns: instr_pc=0 and pc=1, incremented exactly once.
//   4 branch_valid=1, branch_target=16'h0040 during CAPTURE
//     -> no valid for the old fetch; next mem_address=16'h0040, next instr_pc=16'h0040.
//   5 RESET_PC=16'hFFFF; fetch one word
//     -> instr_pc=16'hFFFF, pc=16'h0000, next mem_address=16'h0000.
//   6 reset=1 while in HOLD with ready=0
//     -> next cycle instr_valid=0, instr=0, pc=RESET_PC, mem_req=0, state IDLE.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven instruction fetch with RAM arbitration, valid/ready handoff to decode and branch redirect
module fetch_unit #(
  parameter int DATA_SIZE = 32,
  parameter int ADDRESS_SIZE = 16,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    mem_req,
  input  logic                    mem_grant,
  output logic [ADDRESS_SIZE-1:0] mem_address,
  output logic                    mem_read_write,
  input  logic [DATA_SIZE-1:0]    mem_fetch_data,
  output logic [DATA_SIZE-1:0]    instr,
  output logic [ADDRESS_SIZE-1:0] instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  input  logic                    branch_valid,
  input  logic [ADDRESS_SIZE-1:0] branch_target,
  output logic [ADDRESS_SIZE-1:0] pc
);
  typedef enum logic [1:0] {IDLE, ADDR, CAPTURE, HOLD} state_t;
  state_t                  r_state;
  logic [ADDRESS_SIZE-1:0] r_pc, r_mem_address, r_instr_pc;
  logic [DATA_SIZE-1:0]    r_instr;
  logic                    r_instr_valid, r_mem_req;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_mem_address <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_mem_req     <= 1'b0;
    end else if (branch_valid) begin
      r_pc          <= branch_target;
      r_mem_address <= branch_target;
      r_instr_valid <= 1'b0;
      r_state       <= enable ? ADDR : IDLE;
      r_mem_req     <= enable;
    end else begin
      case (r_state)
        IDLE: if (enable) begin
          r_mem_address <= r_pc;
          r_state       <= ADDR;
          r_mem_req     <= 1'b1;
        end
        ADDR: if (mem_grant) r_state <= CAPTURE;
        CAPTURE: if (mem_grant) begin
          r_instr       <= mem_fetch_data;
          r_instr_pc    <= r_mem_address;
          r_instr_valid <= 1'b1;
          r_pc          <= r_pc + 1'b1;
          r_state       <= HOLD;
          r_mem_req     <= 1'b0;
        end else r_state <= ADDR;
        HOLD: if (instr_ready) begin
          r_instr_valid <= 1'b0;
          r_mem_address <= r_pc;
          r_state       <= enable ? ADDR : IDLE;
          r_mem_req     <= enable;
        end
      endcase
    end
  end
  assign mem_req        = r_mem_req;
  assign mem_address    = r_mem_address;
  assign mem_read_write = 1'b1;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_valid    = r_instr_valid;
  assign pc             = r_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven check of fetch_unit plus a wrap-around RESET_PC instance
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, enable, grant, ready, bv;
  logic [15:0] bt;
  logic        req0, rw0, v0, req1, rw1, v1;
  logic [15:0] addr0, ipc0, pc0, addr1, ipc1, pc1;
  logic [31:0] ins0, ins1, data0, data1;
  assign data0 = 32'hA5A50001 + {16'h0, addr0};
  assign data1 = 32'hA5A50001 + {16'h0, addr1};
  fetch_unit u0 (
    .clk(clk), .reset(reset), .enable(enable), .mem_req(req0), .mem_grant(grant),
    .mem_address(addr0), .mem_read_write(rw0), .mem_fetch_data(data0), .instr(ins0),
    .instr_pc(ipc0), .instr_valid(v0), .instr_ready(ready), .branch_valid(bv),
    .branch_target(bt), .pc(pc0)
  );
  fetch_unit #(.RESET_PC(16'hFFFF)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .mem_req(req1), .mem_grant(grant),
    .mem_address(addr1), .mem_read_write(rw1), .mem_fetch_data(data1), .instr(ins1),
    .instr_pc(ipc1), .instr_valid(v1), .instr_ready(ready), .branch_valid(bv),
    .branch_target(bt), .pc(pc1)
  );
  typedef struct {
    logic rst, en, g, r, b;
    logic [15:0] bt;
    logic v;
    logic [31:0] ins;
    logic [15:0] ipc, pc;
    logic req;
    logic [15:0] addr;
  } vec_t;
  vec_t tbl [29];
  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic rs, input logic en, input logic g, input logic r, input logic b, input logic [15:0] t);
    reset = rs; enable = en; grant = g; ready = r; bv = b; bt = t;
    @(posedge clk); #1;
  endtask
  initial begin
    //          rst en g  r  b  bt        v  instr         ipc       pc        req addr
    tbl[0]  = '{1, 0, 0, 0, 0, 16'h0,    0, 32'h0,        16'h0,    16'h0,    0, 16'h0};
    tbl[1]  = '{0, 1, 1, 1, 0, 16'h0,    0, 32'h0,        16'h0,    16'h0,    1, 16'h0};
    tbl[2]  = '{0, 1, 1, 1, 0, 16'h0,    0, 32'h0,        16'h0,    16'h0,    1, 16'h0};
    tbl[3]  = '{0, 1, 1, 1, 0, 16'h0,    1, 32'hA5A50001, 16'h0,    16'h1,    0, 16'h0};
    tbl[4]  = '{0, 1, 1, 0, 0, 16'h0,    1, 32'hA5A50001, 16'h0,    16'h1,    0, 16'h0};
    tbl[5]  = '{0, 1, 1, 0, 0, 16'h0,    1, 32'hA5A50001, 16'h0,    16'h1,    0, 16'h0};
    tbl[6]  = '{0, 1, 1, 0, 0, 16'h0,    1, 32'hA5A50001, 16'h0,    16'h1,    0, 16'h0};
    tbl[7]  = '{0, 1, 1, 0, 0, 16'h0,    1, 32'hA5A50001, 16'h0,    16'h1,    0, 16'h0};
    tbl[8]  = '{0, 1, 1, 0, 0, 16'h0,    1, 32'hA5A50001, 16'h0,    16'h1,    0, 16'h0};
    tbl[9]  = '{0, 1, 1, 1, 0, 16'h0,    0, 32'hA5A50001, 16'h0,    16'h1,    1, 16'h1};
    tbl[10] = '{0, 1, 1, 1, 0, 16'h0,    0, 32'hA5A50001, 16'h0,    16'h1,    1, 16'h1};
    tbl[11] = '{0, 1, 0, 1, 0, 16'h0,    0, 32'hA5A50001, 16'h0,    16'h1,    1, 16'h1};
    tbl[12] = '{0, 1, 1, 1, 0, 16'h0,    0, 32'hA5A50001, 16'h0,    16'h1,    1, 16'h1};
    tbl[13] = '{0, 1, 1, 1, 0, 16'h0,    1, 32'hA5A50002, 16'h1,    16'h2,    0, 16'h1};
    tbl[14] = '{0, 1, 1, 1, 0, 16'h0,    0, 32'hA5A50002, 16'h1,    16'h2,    1, 16'h2};
    tbl[15] = '{0, 1, 1, 1, 0, 16'h0,    0, 32'hA5A50002, 16'h1,    16'h2,    1, 16'h2};
    tbl[16] = '{0, 1, 1, 1, 1, 16'h0040, 0, 32'hA5A50002, 16'h1,    16'h0040, 1, 16'h0040};
    tbl[17] = '{0, 1, 1, 1, 0, 16'h0,    0, 32'hA5A50002, 16'h1,    16'h0040, 1, 16'h0040};
    tbl[18] = '{0, 1, 1, 0, 0, 16'h0,    1, 32'hA5A50041, 16'h0040, 16'h0041, 0, 16'h0040};
    tbl[19] = '{0, 0, 1, 1, 1, 16'h0010, 0, 32'hA5A50041, 16'h0040, 16'h0010, 0, 16'h0010};
    tbl[20] = '{0, 0, 1, 1, 0, 16'h0,    0, 32'hA5A50041, 16'h0040, 16'h0010, 0, 16'h0010};
    tbl[21] = '{0, 1, 1, 0, 0, 16'h0,    0, 32'hA5A50041, 16'h0040, 16'h0010, 1, 16'h0010};
    tbl[22] = '{0, 1, 1, 0, 0, 16'h0,    0, 32'hA5A50041, 16'h0040, 16'h0010, 1, 16'h0010};
    tbl[23] = '{0, 0, 1, 0, 0, 16'h0,    1, 32'hA5A50011, 16'h0010, 16'h0011, 0, 16'h0010};
    tbl[24] = '{0, 0, 1, 1, 0, 16'h0,    0, 32'hA5A50011, 16'h0010, 16'h0011, 0, 16'h0011};
    tbl[25] = '{0, 1, 1, 0, 0, 16'h0,    0, 32'hA5A50011, 16'h0010, 16'h0011, 1, 16'h0011};
    tbl[26] = '{0, 1, 1, 0, 0, 16'h0,    0, 32'hA5A50011, 16'h0010, 16'h0011, 1, 16'h0011};
    tbl[27] = '{0, 1, 1, 0, 0, 16'h0,    1, 32'hA5A50012, 16'h0011, 16'h0012, 0, 16'h0011};
    tbl[28] = '{1, 1, 1, 0, 0, 16'h0,    0, 32'h0,        16'h0,    16'h0,    0, 16'h0};
    reset = 1'b1; enable = 1'b0; grant = 1'b0; ready = 1'b0; bv = 1'b0; bt = '0;
    @(negedge clk);
    for (int i = 0; i < 29; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].g, tbl[i].r, tbl[i].b, tbl[i].bt);
      tests++;
      if ({v0, ins0, ipc0, pc0, req0, addr0} !== {tbl[i].v, tbl[i].ins, tbl[i].ipc, tbl[i].pc, tbl[i].req, tbl[i].addr}) begin
        fails++;
        $display("FAIL vec%0d: got v=%b instr=%h ipc=%h pc=%h req=%b addr=%h expected v=%b instr=%h ipc=%h pc=%h req=%b addr=%h",
                 i, v0, ins0, ipc0, pc0, req0, addr0,
                 tbl[i].v, tbl[i].ins, tbl[i].ipc, tbl[i].pc, tbl[i].req, tbl[i].addr);
      end
    end
    chk("read_write", {63'h0, rw0}, 64'h1);
    step(1, 0, 0, 0, 0, 16'h0);
    chk("wrap_reset_pc", {48'h0, pc1}, 64'hFFFF);
    chk("wrap_reset_addr", {48'h0, addr1}, 64'hFFFF);
    step(0, 1, 1, 0, 0, 16'h0);
    step(0, 1, 1, 0, 0, 16'h0);
    step(0, 1, 1, 0, 0, 16'h0);
    chk("wrap_valid", {63'h0, v1}, 64'h1);
    chk("wrap_instr", {32'h0, ins1}, 64'hA5A60000);
    chk("wrap_instr_pc", {48'h0, ipc1}, 64'hFFFF);
    chk("wrap_pc", {48'h0, pc1}, 64'h0);
    step(0, 1, 1, 1, 0, 16'h0);
    chk("wrap_next_addr", {48'h0, addr1}, 64'h0);
    chk("wrap_next_req", {63'h0, req1}, 64'h1);
    step(0, 1, 0, 1, 0, 16'h0);
    step(0, 1, 0, 1, 0, 16'h0);
    chk("no_grant_stall_valid", {63'h0, v1}, 64'h0);
    chk("no_grant_stall_pc", {48'h0, pc1}, 64'h0);
    chk("no_grant_stall_req", {63'h0, req1}, 64'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
